// File: rtl/cam_capture_rgb.sv
// OV7670 PCLK-domain capture: builds RGB565 pixels from byte pairs, converts them to OUT_FMT
// and writes them linearly into the frame buffer. Optional 2x decimation via CAP_DECIM2_EN.
module cam_capture_rgb #(
  parameter int OUT_FMT = 0,
  parameter int DW      = 8,
  parameter int H_PIX   = 160,
  parameter int V_LINES = 120,
  parameter int ADDR_W  = 15
) (
  input  logic              PCLK,
  input  logic              rst,
  input  logic              VSYNC,
  input  logic              HREF,
  input  logic [7:0]        D,
  input  logic              capture_en,
  output logic [DW-1:0]     DP_RAM_data_in,
  output logic [ADDR_W-1:0] DP_RAM_addr_in,
  output logic              DP_RAM_regW,
  output logic              frame_done,
  output logic              busy,
  output logic              line_err
);

`ifdef CAP_DECIM2_EN
  localparam int DEC = 2;
`else
  localparam int DEC = 1;
`endif
  localparam int COL_LIM = DEC * H_PIX;
  localparam int ROW_LIM = DEC * V_LINES;
  localparam int CW      = $clog2(COL_LIM + 1);
  localparam int RW      = $clog2(ROW_LIM + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_FRAME = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state;
  logic              vs_q, vs_d, href_q, href_d;
  logic [7:0]        d_q, hi;
  logic              phase;
  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       pix, cv;
  logic              vs_rise, vs_fall, href_fall, take;

  assign vs_rise   = vs_q & ~vs_d;
  assign vs_fall   = ~vs_q & vs_d;
  assign href_fall = ~href_q & href_d;
  assign pix       = {hi, d_q};

`ifdef CAP_DECIM2_EN
  // counters track the full-size source; only even column/line pixels are kept
  assign take = (col < CW'(COL_LIM)) && (row < RW'(ROW_LIM)) && !col[0] && !row[0];
`else
  assign take = (col < CW'(COL_LIM)) && (row < RW'(ROW_LIM));
`endif

  always_comb begin
    cv = pix;
    case (OUT_FMT)
      0:       cv = {8'h00, pix[15:13], pix[10:8], pix[4:3]};
      1:       cv = {4'h0, pix[15:12], pix[10:7], pix[4:1]};
      default: cv = pix;
    endcase
  end

  assign busy       = (state == S_WAIT) || (state == S_FRAME);
  assign frame_done = (state == S_DONE);

  always_ff @(posedge PCLK or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      vs_q           <= 1'b0;
      vs_d           <= 1'b0;
      href_q         <= 1'b0;
      href_d         <= 1'b0;
      d_q            <= '0;
      hi             <= '0;
      phase          <= 1'b0;
      col            <= '0;
      row            <= '0;
      wr_addr        <= '0;
      DP_RAM_data_in <= '0;
      DP_RAM_addr_in <= '0;
      DP_RAM_regW    <= 1'b0;
      line_err       <= 1'b0;
    end else begin
      vs_q        <= VSYNC;
      vs_d        <= vs_q;
      href_q      <= HREF;
      href_d      <= href_q;
      d_q         <= D;
      DP_RAM_regW <= 1'b0;
      case (state)
        S_IDLE: if (capture_en) state <= S_WAIT;
        S_WAIT: if (vs_fall) begin
          state    <= S_FRAME;
          row      <= '0;
          col      <= '0;
          wr_addr  <= '0;
          phase    <= 1'b0;
          line_err <= 1'b0;
        end
        S_FRAME: begin
          if (vs_rise) begin
            // frame cut short inside an active line: flag it, drop any half pixel
            state <= S_DONE;
            phase <= 1'b0;
            if (href_q) line_err <= 1'b1;
          end else if (href_q) begin
            if (!phase) begin
              hi    <= d_q;
              phase <= 1'b1;
            end else begin
              phase <= 1'b0;
              if (take) begin
                DP_RAM_regW    <= 1'b1;
                DP_RAM_data_in <= cv[DW-1:0];
                DP_RAM_addr_in <= wr_addr;
                wr_addr        <= wr_addr + ADDR_W'(1);
              end
              if (col != CW'(COL_LIM)) col <= col + CW'(1);
            end
          end else if (href_fall) begin
            if (phase) line_err <= 1'b1;
            phase <= 1'b0;
            col   <= '0;
            if (row != RW'(ROW_LIM)) row <= row + RW'(1);
          end
        end
        S_DONE:  state <= capture_en ? S_WAIT : S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cam_capture_rgb.sv
// Bench for cam_capture_rgb: three format instances on one camera stream, a frame-level
// reference model of expected writes, table vectors, hand sequences and random frames.
module tb_cam_capture_rgb;
  localparam int H = 4;
  localparam int V = 2;
  localparam int AW = 4;

  logic PCLK = 1'b0;
  logic rst, VSYNC, HREF, capture_en;
  logic [7:0] D;
  logic [7:0]  data0;
  logic [11:0] data1;
  logic [15:0] data2;
  logic [AW-1:0] addr0, addr1, addr2;
  logic wr0, wr1, wr2, fd0, fd1, fd2, busy0, busy1, busy2, err0, err1, err2;

  always #5 PCLK = ~PCLK;

  cam_capture_rgb #(.OUT_FMT(0), .DW(8), .H_PIX(H), .V_LINES(V), .ADDR_W(AW)) u0 (
    .PCLK(PCLK), .rst(rst), .VSYNC(VSYNC), .HREF(HREF), .D(D), .capture_en(capture_en),
    .DP_RAM_data_in(data0), .DP_RAM_addr_in(addr0), .DP_RAM_regW(wr0),
    .frame_done(fd0), .busy(busy0), .line_err(err0));
  cam_capture_rgb #(.OUT_FMT(1), .DW(12), .H_PIX(H), .V_LINES(V), .ADDR_W(AW)) u1 (
    .PCLK(PCLK), .rst(rst), .VSYNC(VSYNC), .HREF(HREF), .D(D), .capture_en(capture_en),
    .DP_RAM_data_in(data1), .DP_RAM_addr_in(addr1), .DP_RAM_regW(wr1),
    .frame_done(fd1), .busy(busy1), .line_err(err1));
  cam_capture_rgb #(.OUT_FMT(2), .DW(16), .H_PIX(H), .V_LINES(V), .ADDR_W(AW)) u2 (
    .PCLK(PCLK), .rst(rst), .VSYNC(VSYNC), .HREF(HREF), .D(D), .capture_en(capture_en),
    .DP_RAM_data_in(data2), .DP_RAM_addr_in(addr2), .DP_RAM_regW(wr2),
    .frame_done(fd2), .busy(busy2), .line_err(err2));

  typedef struct { logic [AW-1:0] addr; logic [15:0] px; } wr_t;
  typedef struct { int nl; int nb; logic [7:0] b0; logic [7:0] b1; logic err; int nw; } vec_t;

  wr_t exp_q[$];
  int  n_chk = 0, n_fail = 0;
  int  nwr = 0, nfd = 0;
  bit  chk_en = 1'b1;
  int  line_nb[8];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] c332(input logic [15:0] px);
    int r, g, b;
    r = px >> 11; g = (px >> 5) & 63; b = px & 31;
    return ((r >> 2) << 5) | ((g >> 3) << 2) | (b >> 3);
  endfunction
  function automatic logic [31:0] c444(input logic [15:0] px);
    int r, g, b;
    r = px >> 11; g = (px >> 5) & 63; b = px & 31;
    return ((r >> 1) << 8) | ((g >> 2) << 4) | (b >> 1);
  endfunction

  always @(negedge PCLK) begin
    if (wr0 || wr1 || wr2) begin
      wr_t e;
      nwr++;
      check("wr_align", {29'd0, wr0, wr1, wr2}, 32'd7);
      if (chk_en) begin
        if (exp_q.size() == 0) check("unexpected_wr", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("addr", addr0, e.addr);
          check("data332", data0, c332(e.px));
          check("data444", data1, c444(e.px));
          check("data565", data2, e.px);
        end
      end
    end
    if (fd0) nfd++;
  end

  // One frame: model derives expected writes from pixel/line position and clip limits
  task automatic frame(input int nl, input bit rnd, input logic [7:0] b0, input logic [7:0] b1,
                       input bit drop_cap);
    logic [AW-1:0] maddr;
    logic [7:0] hi, by;
    logic merr;
    exp_q.delete();
    nwr = 0; nfd = 0; maddr = '0; merr = 1'b0; hi = '0;
    @(negedge PCLK);
    VSYNC = 1'b1; HREF = 1'b0;
    repeat (6) @(negedge PCLK);
    VSYNC = 1'b0;
    repeat (3) @(negedge PCLK);
    check("busy_in_frame", busy0, 1);
    check("err_clr_at_start", err0, 0);
    for (int l = 0; l < nl; l++) begin
      HREF = 1'b1;
      for (int k = 0; k < line_nb[l]; k++) begin
        by = rnd ? 8'($urandom) : ((k % 2) ? b1 : b0);
        D = by;
        if (k % 2 == 0) hi = by;
        else if ((k / 2) < H && l < V) begin
          exp_q.push_back('{maddr, {hi, by}});
          maddr = maddr + 1'b1;
        end
        @(negedge PCLK);
      end
      if (line_nb[l] % 2) merr = 1'b1;
      HREF = 1'b0; D = 8'h00;
      if (drop_cap && l == 0) capture_en = 1'b0;
      repeat (3) @(negedge PCLK);
    end
    VSYNC = 1'b1;
    repeat (6) @(negedge PCLK);
    check("frame_done_pulses", nfd, 1);
    check("missing_writes", exp_q.size(), 0);
    check("line_err", err0, merr);
    check("busy_after", busy0, capture_en);
  endtask

  vec_t vt[5];

  initial begin
    vt[0] = '{2, 8,  8'hF8, 8'h1F, 1'b0, 8};  // basic 2x4 frame, 0xE3 each
    vt[1] = '{1, 2,  8'hAB, 8'hCD, 1'b0, 1};  // format check
    vt[2] = '{3, 12, 8'h12, 8'h34, 1'b0, 8};  // clipping 6px x 3 lines
    vt[3] = '{1, 7,  8'h5A, 8'hA5, 1'b1, 3};  // odd byte line
    vt[4] = '{2, 4,  8'h00, 8'hFF, 1'b0, 4};  // short lines pack, err cleared

    rst = 1'b1; capture_en = 1'b0; VSYNC = 1'b0; HREF = 1'b0; D = 8'h00;
    repeat (3) @(negedge PCLK);
    check("rst_data", data0, 0);
    check("rst_addr", addr0, 0);
    check("rst_wr", wr0, 0);
    check("rst_fd", fd0, 0);
    check("rst_busy", busy0, 0);
    check("rst_err", err0, 0);
    rst = 1'b0;

    // camera active while capture disabled
    nwr = 0; nfd = 0;
    for (int i = 0; i < 40; i++) begin
      VSYNC = (i < 5) || (i > 34);
      HREF  = (i % 10) > 2 && (i % 10) < 9 && !VSYNC;
      D     = 8'(i * 7);
      @(negedge PCLK);
    end
    check("idle_writes", nwr, 0);
    check("idle_fd", nfd, 0);
    check("idle_busy", busy0, 0);

    capture_en = 1'b1;
    foreach (vt[i]) begin
      for (int l = 0; l < 8; l++) line_nb[l] = vt[i].nb;
      frame(vt[i].nl, 1'b0, vt[i].b0, vt[i].b1, 1'b0);
      check("vec_writes", nwr, vt[i].nw);
      check("vec_err", err0, vt[i].err);
      if (i == 0) check("basic_last_addr", addr0, 7);
      if (i == 1) begin
        check("fmt565", data2, 32'hABCD);
        check("fmt444", data1, 32'hA76);
      end
      if (i == 2) check("clip_last_addr", addr0, 7);
    end

    // reset in the middle of a frame
    @(negedge PCLK);
    VSYNC = 1'b1; HREF = 1'b0;
    repeat (6) @(negedge PCLK);
    VSYNC = 1'b0;
    repeat (3) @(negedge PCLK);
    chk_en = 1'b0; nwr = 0;
    HREF = 1'b1;
    for (int k = 0; k < 16; k++) begin
      D = 8'(k + 2);
      @(negedge PCLK);
      if (nwr >= 3) break;
    end
    check("pre_rst_writes", nwr >= 3, 1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_wr", wr0, 0);
    check("mid_rst_addr", addr0, 0);
    check("mid_rst_data", data0, 0);
    check("mid_rst_busy", busy0, 0);
    HREF = 1'b0; VSYNC = 1'b1; D = 8'h00;
    @(negedge PCLK);
    rst = 1'b0;
    exp_q.delete();
    chk_en = 1'b1;
    for (int l = 0; l < 8; l++) line_nb[l] = 8;
    frame(2, 1'b0, 8'h3C, 8'hC3, 1'b0);
    check("post_rst_writes", nwr, 8);

    // capture_en dropped after first line: frame finishes, then idle
    for (int l = 0; l < 8; l++) line_nb[l] = 4;
    frame(2, 1'b0, 8'h11, 8'h22, 1'b1);
    check("drop_writes", nwr, 4);
    repeat (3) @(negedge PCLK);
    check("drop_idle_busy", busy0, 0);

    capture_en = 1'b1;
    for (int f = 0; f < 6; f++) begin
      int nl;
      nl = $urandom_range(1, 4);
      for (int l = 0; l < 8; l++) line_nb[l] = $urandom_range(1, 12);
      frame(nl, 1'b1, 8'h00, 8'h00, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
